// File: rtl/fir_pkg.sv
// Shared widths, saturation limits and quantisation helpers for the FIR output path.
package fir_pkg;

    localparam int unsigned FIR_ACC_W    = 32;
    localparam int unsigned FIR_SAMPLE_W = 16;

    typedef logic signed [FIR_SAMPLE_W-1:0] sample_t;

    localparam sample_t SAT_MAX = 16'sh7FFF;
    localparam sample_t SAT_MIN = 16'sh8000;

    // True when the scaled accumulator does not fit a signed 16-bit sample.
    function automatic logic out_of_range(input logic signed [FIR_ACC_W:0] v);
        return v[FIR_ACC_W:FIR_SAMPLE_W-1] !=
               {(FIR_ACC_W-FIR_SAMPLE_W+2){v[FIR_SAMPLE_W-1]}};
    endfunction

    function automatic sample_t saturate16(input logic signed [FIR_ACC_W:0] v);
        if (!out_of_range(v)) begin
            return v[FIR_SAMPLE_W-1:0];
        end
        return v[FIR_ACC_W] ? SAT_MIN : SAT_MAX;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Output sample FIFO: level-derived full/empty, pointers wrap modulo DEPTH, sticky drop flag.
module fir_out_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     ready,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             pop;
    logic             accept;

    // A push into a full FIFO still lands when the head leaves on the same edge.
    always_comb begin
        full   = (level == FULL_LVL);
        valid  = (level != '0);
        pop    = valid && ready;
        accept = push && (!full || pop);
        dout   = valid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({accept, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_out_stage.sv
// FIR output stage: round/saturate the accumulator to 16 bits, then buffer in fir_out_fifo.
// Define FIR_OUT_SAT_CNT_EN to add the sat_cnt port and saturation counter.
module fir_out_stage
    import fir_pkg::*;
#(
    parameter int unsigned FRAC_BITS = 15,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                    clk_10khz,
    input  logic                    rst_n,
    input  logic [FIR_ACC_W-1:0]    y_in,
    input  logic                    y_valid,
    output logic [FIR_SAMPLE_W-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  level
`ifdef FIR_OUT_SAT_CNT_EN
    ,
    output logic [7:0]              sat_cnt
`endif
);

    localparam logic signed [FIR_ACC_W:0] ROUND = {{FIR_ACC_W{1'b0}}, 1'b1} << (FRAC_BITS - 1);

    logic signed [FIR_ACC_W:0] scaled;
    sample_t                   q;
    logic                      q_valid;

    always_comb begin
        scaled = ($signed({y_in[FIR_ACC_W-1], y_in}) + ROUND) >>> FRAC_BITS;
    end

    always_ff @(posedge clk_10khz or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            q_valid <= y_valid;
            if (y_valid) begin
                q <= saturate16(scaled);
            end
        end
    end

    fir_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIR_SAMPLE_W)
    ) u_fifo (
        .clk      (clk_10khz),
        .rst_n    (rst_n),
        .push     (q_valid),
        .din      (q),
        .ready    (dout_ready),
        .dout     (dout),
        .valid    (dout_valid),
        .level    (level),
        .overflow (overflow)
    );

`ifdef FIR_OUT_SAT_CNT_EN
    localparam logic [$clog2(DEPTH):0] FULL_LVL = DEPTH[$clog2(DEPTH):0];

    logic q_sat;
    logic accepted;

    always_ff @(posedge clk_10khz or negedge rst_n) begin
        if (!rst_n) begin
            q_sat <= 1'b0;
        end else if (y_valid) begin
            q_sat <= out_of_range(scaled);
        end
    end

    // Mirrors the FIFO accept rule so dropped samples are not counted.
    always_comb begin
        accepted = q_valid && ((level != FULL_LVL) || (dout_valid && dout_ready));
    end

    always_ff @(posedge clk_10khz or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= '0;
        end else if (accepted && q_sat && (sat_cnt != 8'hFF)) begin
            sat_cnt <= sat_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_out_stage.sv
// Self-checking bench for fir_out_stage: directed rounding/saturation/fill/reset steps and random backpressure.
module tb_fir_out_stage;

    localparam int unsigned FRAC_BITS = 15;
    localparam int unsigned DEPTH     = 8;

    logic        clk_10khz = 1'b0;
    logic        rst_n     = 1'b1;
    logic [31:0] y_in;
    logic        y_valid;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        overflow;
    logic [3:0]  level;
`ifdef FIR_OUT_SAT_CNT_EN
    logic [7:0]  sat_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [15:0] dir_exp[5] = '{16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000};

    always #5 clk_10khz = ~clk_10khz;

    fir_out_stage #(
        .FRAC_BITS (FRAC_BITS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_10khz  (clk_10khz),
        .rst_n      (rst_n),
        .y_in       (y_in),
        .y_valid    (y_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow),
        .level      (level)
`ifdef FIR_OUT_SAT_CNT_EN
        ,
        .sat_cnt    (sat_cnt)
`endif
    );

    // Reference: y / 2^FRAC_BITS rounded half-up (floor of y + half), then clamped.
    function automatic longint scaled_ref(input logic [31:0] y);
        longint v;
        v = longint'($signed(y)) + (longint'(1) <<< (FRAC_BITS - 1));
        return v >>> FRAC_BITS;
    endfunction

    function automatic logic is_sat(input logic [31:0] y);
        longint v;
        v = scaled_ref(y);
        return (v > 32767) || (v < -32768);
    endfunction

    function automatic logic [15:0] quant(input logic [31:0] y);
        longint v;
        v = scaled_ref(y);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic [31:0] rand_sample();
        logic [31:0] y;
        y = $urandom;
        if ($urandom_range(0, 2) != 0) begin
            y = $signed(y) >>> $urandom_range(4, 12);
        end
        return y;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_10khz);
        #1;
    endtask

    // Drive one cycle; model every presented sample and check each head that leaves.
    task automatic cycle(input logic v, input logic [31:0] y, input logic rdy);
        logic [15:0] head;
        y_valid    = v;
        y_in       = y;
        dout_ready = rdy;
        if (v) exp_q.push_back(quant(y));
        if (dout_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("pop_without_sample", 32'(dout_valid), 32'd0);
            end else begin
                head = exp_q.pop_front();
                check("dout_order", 32'(dout), 32'(head));
            end
        end
        tick();
    endtask

    initial begin
        int          sent;
        int          sats;
        logic        v;
        logic        rdy;
        logic [31:0] y;
        logic        stalled;
        logic [15:0] held;

        y_in       = '0;
        y_valid    = 1'b0;
        dout_ready = 1'b0;
        rst_n      = 1'b0;
        tick();
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
`ifdef FIR_OUT_SAT_CNT_EN
        check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
        tick();
        rst_n = 1'b1;

        // First cycle after reset release, and two-edge latency.
        cycle(1'b1, 32'h0000_4000, 1'b0);
        check("latency_edge1_valid", 32'(dout_valid), 32'd0);
        cycle(1'b0, 32'h0, 1'b0);
        check("latency_edge2_valid", 32'(dout_valid), 32'd1);
        check("round_half_up", 32'(dout), 32'h0001);

        cycle(1'b1, 32'h0000_3FFF, 1'b0);
        cycle(1'b1, 32'hFFFF_C000, 1'b0);
        cycle(1'b1, 32'h4000_0000, 1'b0);
        cycle(1'b1, 32'h8000_0000, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        check("directed_level", 32'(level), 32'd5);
`ifdef FIR_OUT_SAT_CNT_EN
        check("directed_sat_cnt", 32'(sat_cnt), 32'd2);
`endif
        for (int i = 0; i < 5; i++) begin
            check("directed_valid", 32'(dout_valid), 32'd1);
            check("directed_dout", 32'(dout), 32'(dir_exp[i]));
            cycle(1'b0, 32'h0, 1'b1);
        end
        check("drained_level", 32'(level), 32'd0);
        check("drained_valid", 32'(dout_valid), 32'd0);
        cycle(1'b0, 32'h0, 1'b1);
        check("pop_empty_level", 32'(level), 32'd0);

        // Fill to DEPTH, then push+pop while full, then a dropped push.
        for (int i = 0; i < 8; i++) cycle(1'b1, rand_sample(), 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        check("full_level", 32'(level), 32'd8);
        check("full_overflow", 32'(overflow), 32'd0);
        check("full_head", 32'(dout), 32'(exp_q[0]));
        cycle(1'b1, rand_sample(), 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
        check("full_pushpop_level", 32'(level), 32'd8);
        check("full_pushpop_overflow", 32'(overflow), 32'd0);
        cycle(1'b1, rand_sample(), 1'b0);
        void'(exp_q.pop_back());
        cycle(1'b0, 32'h0, 1'b0);
        check("drop_level", 32'(level), 32'd8);
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_head", 32'(dout), 32'(exp_q[0]));
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);
        check("drop_drain_model", 32'(exp_q.size()), 32'd0);
        check("drop_drain_level", 32'(level), 32'd0);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Asynchronous reset with five samples buffered.
        for (int i = 0; i < 5; i++) cycle(1'b1, rand_sample(), 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        check("prereset_level", 32'(level), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_valid", 32'(dout_valid), 32'd0);
        check("async_rst_overflow", 32'(overflow), 32'd0);
        check("async_rst_dout", 32'(dout), 32'd0);
`ifdef FIR_OUT_SAT_CNT_EN
        check("async_rst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        tick();

        // Random backpressure over 128 samples; in-flight kept within DEPTH so none drop.
        sent    = 0;
        sats    = 0;
        stalled = 1'b0;
        held    = '0;
        for (int c = 0; c < 3000 && (sent < 128 || exp_q.size() != 0); c++) begin
            rdy = 1'($urandom_range(0, 1));
            v   = (sent < 128) && (exp_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            y   = v ? rand_sample() : 32'h0;
            if (stalled) begin
                check("stall_valid", 32'(dout_valid), 32'd1);
                check("stall_hold", 32'(dout), 32'(held));
            end
            stalled = dout_valid && !rdy;
            held    = dout;
            if (v) begin
                sent++;
                if (is_sat(y)) sats++;
            end
            cycle(v, y, rdy);
        end
        check("bp_all_sent", 32'(sent), 32'd128);
        check("bp_all_received", 32'(exp_q.size()), 32'd0);
        check("bp_overflow", 32'(overflow), 32'd0);
        check("bp_level", 32'(level), 32'd0);
`ifdef FIR_OUT_SAT_CNT_EN
        check("bp_sat_cnt", 32'(sat_cnt), 32'((sats > 255) ? 255 : sats));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
